// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_wait_responder slice.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - little-endian byte-lane select constants
//   - wait-state range limit and the captured-operation struct
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // addr[1:0] lane select, lane 0 = bits [7:0]
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  // Wait counter is 4 bits wide, so 15 is the largest wait count.
  localparam int WAIT_CYCLES_MAX = 15;
  localparam int WAIT_CNT_W      = 4;

  // Access type latched at request capture.
  typedef struct packed {
    logic wren;
    logic sb;
    logic lb;
    logic lbu;
  } dmem_op_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane helper for dmem_wait_responder.
//   word_i  : current RAM word
//   lane_i  : byte lane (addr[1:0])
//   byte_i  : store byte for sb
//   lb_i    : sign-extending byte load (wins over lbu_i)
//   lbu_i   : zero-extending byte load
//   load_o  : load result (byte extended, or full word if neither set)
//   merge_o : word_i with byte_i merged into the selected lane
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  input  logic        lb_i,
  input  logic        lbu_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = word_i[7:0];
    merge_o  = word_i;
    case (lane_i)
      LANE_B0: begin sel_byte = word_i[7:0];   merge_o[7:0]   = byte_i; end
      LANE_B1: begin sel_byte = word_i[15:8];  merge_o[15:8]  = byte_i; end
      LANE_B2: begin sel_byte = word_i[23:16]; merge_o[23:16] = byte_i; end
      LANE_B3: begin sel_byte = word_i[31:24]; merge_o[31:24] = byte_i; end
      default: ;
    endcase
  end

  always_comb begin
    if (lb_i)       load_o = {{24{sel_byte[7]}}, sel_byte};
    else if (lbu_i) load_o = {24'b0, sel_byte};
    else            load_o = word_i;
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with req/ack handshake and programmable wait states.
// Serves sw/sb/lw/lb/lbu from an internal 2**ADDR_W x 32 word RAM.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   req   : access request, held until ack
//   wren  : 1 = store, 0 = load
//   sb    : byte store          lb/lbu : signed / unsigned byte load
//   addr  : byte address        wdata  : store data
//   ack   : one-cycle completion pulse
//   rdata : load result, valid with ack, held otherwise
//   err   : misaligned word access flag, valid with ack
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned word access traps
// with err=1, store suppressed, rdata=0). Undefined: err is tied to 0.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wren,
  input  logic        sb,
  input  logic        lb,
  input  logic        lbu,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  // Out-of-range wait counts saturate at the counter limit.
  localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX :
                            (WAIT_CYCLES < 0) ? 0 : WAIT_CYCLES;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_EFF);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  dmem_op_t              op_q;
  logic [ADDR_W+1:0]     addr_q;
  logic [31:0]           wdata_q;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] ram [2**ADDR_W];

  logic              cap_en;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [31:0]       load_data;
  logic [31:0]       merge_word;
  logic              word_acc;
  logic              misalign;
  logic              addr_unused;

  // Only the word index and lane are decoded; upper bits wrap.
  assign addr_unused = &{1'b0, addr[31:ADDR_W+2]};

  // The ack cycle is spent in IDLE with req still high (requester drops it on
  // the edge ending ack), so capture is blocked while ack is out.
  assign cap_en = (state_q == ST_IDLE) && req && !ack_q;

  assign widx    = addr_q[ADDR_W+1:2];
  assign lane    = addr_q[1:0];
  assign rd_word = ram[widx];

  assign word_acc = op_q.wren ? !op_q.sb : !(op_q.lb || op_q.lbu);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = word_acc && (lane != LANE_B0);
`else
  assign misalign = 1'b0;
`endif

  dmem_lane_align u_align (
    .word_i  (rd_word),
    .lane_i  (lane),
    .byte_i  (wdata_q[7:0]),
    .lb_i    (op_q.lb),
    .lbu_i   (op_q.lbu),
    .load_o  (load_data),
    .merge_o (merge_word)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_en) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_EFF == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. The access is resolved during RESP and registered on the
  // edge ending RESP, so the read sees the pre-write RAM value.
  always_comb begin
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    ram_wdata = op_q.sb ? merge_word : wdata_q;
    if (state_q == ST_RESP) begin
      ack_d = 1'b1;
      if (misalign) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end else if (op_q.wren) begin
        ram_we = 1'b1;
      end else begin
        rdata_d = load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture registers: operands are frozen for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (cap_en) begin
      op_q    <= '{wren: wren, sb: sb, lb: lb, lbu: lbu};
      addr_q  <= addr[ADDR_W+1:0];
      wdata_q <= wdata;
    end
  end

  // RAM is not reset; an async reset forces state_q out of RESP so no write.
  always_ff @(posedge clk) begin
    if (ram_we) ram[widx] <= ram_wdata;
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req0 = 1'b0;
  logic        wren = 1'b0, sb = 1'b0, lb = 1'b0, lbu = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ack, err, ack0, err0;
  logic [31:0] rdata, rdata0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .wren(wren), .sb(sb), .lb(lb), .lbu(lbu),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err)
  );

  dmem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .wren(wren), .sb(sb), .lb(lb), .lbu(lbu),
    .addr(addr), .wdata(wdata), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: request at a negedge, count negedges until ack, check latency,
  // then check that ack is a single-cycle pulse.
  task automatic access(input bit sel, input logic w, input logic s, input logic b,
                        input logic bu, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input string tag,
                        output logic [31:0] rd, output logic er);
    int  n;
    bit  got;
    @(negedge clk);
    wren = w; sb = s; lb = b; lbu = bu; addr = a; wdata = d;
    if (sel) req0 = 1'b1; else req = 1'b1;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      got = sel ? ack0 : ack;
    end
    req = 1'b0; req0 = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    rd = sel ? rdata0 : rdata;
    er = sel ? err0 : err;
    @(negedge clk);
    chk({tag, "_ackpulse"}, {31'b0, sel ? ack0 : ack}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b1;

    // sw / lw
    access(0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 4, "sw10", rd, er);
    chk("sw10_err", {31'b0, er}, 32'd0);
    access(0, 0, 0, 0, 0, 32'h10, 32'h0, 4, "lw10", rd, er);
    chk("lw10_data", rd, 32'hDEADBEEF);
    chk("lw10_hold", rdata, 32'hDEADBEEF);

    // sb into lane 1
    access(0, 1, 1, 0, 0, 32'h11, 32'h000000A5, 4, "sb11", rd, er);
    access(0, 0, 0, 0, 0, 32'h10, 32'h0, 4, "lw10b", rd, er);
    chk("lw10b_data", rd, 32'hDEADA5EF);

    // byte loads
    access(0, 0, 0, 1, 0, 32'h11, 32'h0, 4, "lb11", rd, er);
    chk("lb11_data", rd, 32'hFFFFFFA5);
    access(0, 0, 0, 0, 1, 32'h11, 32'h0, 4, "lbu11", rd, er);
    chk("lbu11_data", rd, 32'h000000A5);
    access(0, 0, 0, 1, 1, 32'h11, 32'h0, 4, "lblbu11", rd, er);
    chk("lblbu11_data", rd, 32'hFFFFFFA5);
    access(0, 0, 0, 1, 0, 32'h10, 32'h0, 4, "lb10", rd, er);
    chk("lb10_data", rd, 32'hFFFFFFEF);
    access(0, 0, 0, 1, 0, 32'h13, 32'h0, 4, "lb13", rd, er);
    chk("lb13_data", rd, 32'hFFFFFFDE);
    access(0, 0, 0, 0, 1, 32'h12, 32'h0, 4, "lbu12", rd, er);
    chk("lbu12_data", rd, 32'h000000AD);

    // address wrap modulo 256 words
    access(0, 1, 0, 0, 0, 32'h400, 32'h12345678, 4, "sw400", rd, er);
    access(0, 0, 0, 0, 0, 32'h000, 32'h0, 4, "lw000", rd, er);
    chk("wrap_data", rd, 32'h12345678);

    // req dropped and addr/wdata changed after capture
    begin
      int  n;
      bit  got;
      @(negedge clk);
      wren = 1; sb = 0; lb = 0; lbu = 0; addr = 32'h20; wdata = 32'h0BADF00D; req = 1;
      @(negedge clk);
      req = 0; addr = 32'h24; wdata = 32'h0; wren = 0;
      n = 1; got = ack;
      while (n < 20 && !got) begin
        @(negedge clk);
        n++;
        got = ack;
      end
      chk("drop_lat", 32'(n), 32'd4);
      @(negedge clk);
    end
    access(0, 0, 0, 0, 0, 32'h20, 32'h0, 4, "lw20", rd, er);
    chk("drop_data", rd, 32'h0BADF00D);

    // reset in WAIT aborts a store
    begin
      bit saw_ack;
      @(negedge clk);
      wren = 1; sb = 0; lb = 0; lbu = 0; addr = 32'h10; wdata = 32'hCAFEF00D; req = 1;
      @(negedge clk);
      rst = 0; req = 0;
      saw_ack = 0;
      repeat (5) begin
        @(negedge clk);
        if (ack) saw_ack = 1;
      end
      chk("abort_noack", {31'b0, saw_ack}, 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      rst = 1;
      saw_ack = 0;
      repeat (5) begin
        @(negedge clk);
        if (ack) saw_ack = 1;
      end
      chk("abort_noack_after", {31'b0, saw_ack}, 32'd0);
    end
    access(0, 0, 0, 0, 0, 32'h10, 32'h0, 4, "lw10c", rd, er);
    chk("abort_mem", rd, 32'hDEADA5EF);

    // zero wait states
    access(1, 1, 0, 0, 0, 32'h4, 32'hA5A55A5A, 2, "w0_sw", rd, er);
    access(1, 0, 0, 0, 0, 32'h4, 32'h0, 2, "w0_lw", rd, er);
    chk("w0_data", rd, 32'hA5A55A5A);
    access(1, 0, 0, 0, 1, 32'h7, 32'h0, 2, "w0_lbu", rd, er);
    chk("w0_lbu_data", rd, 32'h000000A5);

    // misaligned word access
    access(0, 1, 0, 0, 0, 32'h13, 32'h11223344, 4, "sw13", rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("sw13_err", {31'b0, er}, 32'd1);
    access(0, 0, 0, 0, 0, 32'h10, 32'h0, 4, "lw10d", rd, er);
    chk("sw13_mem", rd, 32'hDEADA5EF);
    chk("lw10d_err", {31'b0, er}, 32'd0);
    access(0, 0, 0, 0, 0, 32'h12, 32'h0, 4, "lw12", rd, er);
    chk("lw12_data", rd, 32'd0);
    chk("lw12_err", {31'b0, er}, 32'd1);
`else
    chk("sw13_err", {31'b0, er}, 32'd0);
    access(0, 0, 0, 0, 0, 32'h10, 32'h0, 4, "lw10d", rd, er);
    chk("sw13_mem", rd, 32'h11223344);
    access(0, 0, 0, 0, 0, 32'h12, 32'h0, 4, "lw12", rd, er);
    chk("lw12_data", rd, 32'h11223344);
    chk("lw12_err", {31'b0, er}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
